// File: rtl/color_seq_pkg.sv
// Shared types for the colour sequencer: state and command encodings,
// dwell counter sizing and the ring-step helper.
package color_seq_pkg;

  typedef enum logic [1:0] {
    BLUE   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } Color_state;

  typedef enum logic [1:0] {
    CMD_HOLD    = 2'd0,
    CMD_ADVANCE = 2'd1,
    CMD_REVERSE = 2'd2,
    CMD_HOME    = 2'd3
  } cmd_e;

  localparam int DWELL_W = 8;

  // One step around a ring of num_states colours; dir=1 forward, dir=0 back.
  function automatic Color_state next_idx(input Color_state idx, input logic dir,
                                          input int unsigned num_states);
    int unsigned i;
    int unsigned n;
    i = {30'd0, idx};
    if (dir) n = (i + 1 >= num_states) ? 0 : i + 1;
    else     n = (i == 0) ? num_states - 1 : i - 1;
    return Color_state'(n[1:0]);
  endfunction

endpackage

// File: rtl/color_seq_dwell.sv
// Dwell timer for the colour sequencer: saturating cycle count since state
// entry, the command-ready window and (with COLOR_SEQ_AUTO_EN) the
// auto-advance strobe.
module color_seq_dwell
  import color_seq_pkg::*;
#(
  parameter int MIN_DWELL  = 2,
  parameter int AUTO_DWELL = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic ready_o
`ifdef COLOR_SEQ_AUTO_EN
  ,
  output logic auto_fire_o
`endif
);

  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_d;

  // Restart at zero on state entry, otherwise count up and stick at 255.
  always_comb begin
    dwell_d = dwell_q;
    if (clear_i)                 dwell_d = '0;
    else if (dwell_q != 8'hFF)   dwell_d = dwell_q + 8'd1;
  end

  // Dwell count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end

  // Ready is a pure function of the registered count.
  generate
    if (MIN_DWELL <= 1) begin : g_ready_always
      assign ready_o = 1'b1;
    end else begin : g_ready_cmp
      assign ready_o = (dwell_q >= 8'(MIN_DWELL - 1));
    end
  endgenerate

`ifdef COLOR_SEQ_AUTO_EN
  assign auto_fire_o = (dwell_q == 8'(AUTO_DWELL - 1));
`endif

endmodule

// File: rtl/color_seq_fsm.sv
// Colour ring sequencer. Steps through up to four colours on ADVANCE /
// REVERSE / HOME commands, gated by a minimum dwell per state. Outputs are
// registered and decoded from the state only.
// Optional: define COLOR_SEQ_AUTO_EN to auto-advance after AUTO_DWELL cycles.
module color_seq_fsm
  import color_seq_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int HOME       = 1,
  parameter int MIN_DWELL  = 2,
  parameter int AUTO_DWELL = 16,
  parameter int OUT_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           cmd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic [1:0]           state_idx,
  output logic                 changed
);

  localparam Color_state HOME_ST = Color_state'(2'(HOME));

  function automatic logic [OUT_WIDTH-1:0] color_code(input Color_state s);
    return OUT_WIDTH'({1'b0, s} + 3'd1);
  endfunction

  Color_state           state_q, state_d;
  logic                 changed_q;
  logic [OUT_WIDTH-1:0] out_q;
  logic                 accept;
  logic                 enter;

  assign accept = cmd_valid & cmd_ready;

`ifdef COLOR_SEQ_AUTO_EN
  logic auto_fire;
  logic cmd_moves;
  // Any accepted non-HOLD command pre-empts the auto step, even a HOME that
  // leaves the state where it is.
  assign cmd_moves = accept & (cmd != CMD_HOLD);
`endif

  color_seq_dwell #(
    .MIN_DWELL  (MIN_DWELL),
    .AUTO_DWELL (AUTO_DWELL)
  ) u_dwell (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (enter),
    .ready_o     (cmd_ready)
`ifdef COLOR_SEQ_AUTO_EN
    ,
    .auto_fire_o (auto_fire)
`endif
  );

  // Next state from the accepted command, then the optional auto step.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (cmd)
        CMD_ADVANCE: state_d = next_idx(state_q, 1'b1, NUM_STATES);
        CMD_REVERSE: state_d = next_idx(state_q, 1'b0, NUM_STATES);
        CMD_HOME:    state_d = HOME_ST;
        CMD_HOLD:    state_d = state_q;
      endcase
    end
`ifdef COLOR_SEQ_AUTO_EN
    if (!cmd_moves && auto_fire) state_d = next_idx(state_q, 1'b1, NUM_STATES);
`endif
    enter = (state_d != state_q);
  end

  // State register with registered Moore outputs; change pulse only on a real move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HOME_ST;
      changed_q <= 1'b0;
      out_q     <= color_code(HOME_ST);
    end else begin
      state_q   <= state_d;
      changed_q <= enter;
      out_q     <= color_code(state_d);
    end
  end

  assign out       = out_q;
  assign state_idx = state_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_color_seq_fsm.sv
// Bench for color_seq_fsm: two instances (4-state/MIN 3/AUTO 4 and
// 3-state/MIN 1/AUTO 8) with a ring-arithmetic reference model.
module tb_color_seq_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] a_cmd, b_cmd;
  logic       a_vld, b_vld;
  logic       a_rdy, b_rdy, a_chg, b_chg;
  logic [2:0] a_out;
  logic [3:0] b_out;
  logic [1:0] a_idx, b_idx;

  color_seq_fsm #(.NUM_STATES(4), .HOME(1), .MIN_DWELL(3), .AUTO_DWELL(4), .OUT_WIDTH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(a_cmd), .cmd_valid(a_vld), .cmd_ready(a_rdy),
    .out(a_out), .state_idx(a_idx), .changed(a_chg));

  color_seq_fsm #(.NUM_STATES(3), .HOME(1), .MIN_DWELL(1), .AUTO_DWELL(8), .OUT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(b_cmd), .cmd_valid(b_vld), .cmd_ready(b_rdy),
    .out(b_out), .state_idx(b_idx), .changed(b_chg));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: colour index, cycles since entry, change flag.
  int m_idx[2];
  int m_dw[2];
  bit m_chg[2];

  function automatic int nst(input int d);   return (d == 0) ? 4 : 3; endfunction
  function automatic int mind(input int d);  return (d == 0) ? 3 : 1; endfunction
  function automatic int autod(input int d); return (d == 0) ? 4 : 8; endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 1; m_dw[d] = 0; m_chg[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d, input logic v, input logic [1:0] c);
    int  n, nx;
    bit  expl;
    n = nst(d); nx = m_idx[d]; expl = 1'b0;
    if (v && m_dw[d] >= mind(d) - 1) begin
      if (c == 2'd1)      begin nx = (m_idx[d] + 1) % n;     expl = 1'b1; end
      else if (c == 2'd2) begin nx = (m_idx[d] + n - 1) % n; expl = 1'b1; end
      else if (c == 2'd3) begin nx = 1;                      expl = 1'b1; end
    end
`ifdef COLOR_SEQ_AUTO_EN
    if (!expl && m_dw[d] == autod(d) - 1) nx = (m_idx[d] + 1) % n;
`endif
    if (nx != m_idx[d]) begin
      m_idx[d] = nx; m_dw[d] = 0; m_chg[d] = 1'b1;
    end else begin
      m_dw[d] = (m_dw[d] < 255) ? m_dw[d] + 1 : 255; m_chg[d] = 1'b0;
    end
  endtask

  // Advance one clock (called at a negedge, returns at the next negedge).
  task automatic clk_step();
    @(posedge clk);
    if (rst_n) begin
      model_edge(0, a_vld, a_cmd);
      model_edge(1, b_vld, b_cmd);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_vld = 1'b0; b_vld = 1'b0; a_cmd = 2'd0; b_cmd = 2'd0;
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_reset();
    n_tests++; if (a_out !== 3'd2) begin n_fail++; $display("FAIL reset_a_out act=%0d exp=2", a_out); end
    n_tests++; if (a_idx !== 2'd1) begin n_fail++; $display("FAIL reset_a_idx act=%0d exp=1", a_idx); end
    n_tests++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL reset_a_chg act=%0b exp=0", a_chg); end
    n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_a_rdy act=%0b exp=0", a_rdy); end
    n_tests++; if (b_out !== 4'd2) begin n_fail++; $display("FAIL reset_b_out act=%0d exp=2", b_out); end
    n_tests++; if (b_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_b_rdy act=%0b exp=1", b_rdy); end
    rst_n = 1'b1;
  endtask

  task automatic test_dwell_gating();
    do_reset();
    a_vld = 1'b1; a_cmd = 2'd1;
    n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL gate_rdy_d0 act=%0b exp=0", a_rdy); end
    clk_step();
    n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL gate_rdy_d1 act=%0b exp=0", a_rdy); end
    n_tests++; if (a_out !== 3'd2) begin n_fail++; $display("FAIL gate_out_d1 act=%0d exp=2", a_out); end
    clk_step();
    n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL gate_rdy_d2 act=%0b exp=1", a_rdy); end
    n_tests++; if (a_out !== 3'd2) begin n_fail++; $display("FAIL gate_out_d2 act=%0d exp=2", a_out); end
    clk_step();
    n_tests++; if (a_out !== 3'd3) begin n_fail++; $display("FAIL gate_out_acc act=%0d exp=3", a_out); end
    n_tests++; if (a_chg !== 1'b1) begin n_fail++; $display("FAIL gate_chg_acc act=%0b exp=1", a_chg); end
    n_tests++; if (a_rdy !== 1'b0) begin n_fail++; $display("FAIL gate_rdy_acc act=%0b exp=0", a_rdy); end
    a_vld = 1'b0;
    clk_step();
    n_tests++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL gate_chg_once act=%0b exp=0", a_chg); end
    n_tests++; if (a_out !== 3'd3) begin n_fail++; $display("FAIL gate_out_hold act=%0d exp=3", a_out); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_vld = 1'b1; a_cmd = 2'd1;
    repeat (6) clk_step();
    n_tests++; if (a_idx !== 2'd3 || a_out !== 3'd4) begin n_fail++; $display("FAIL mid_yellow act=%0d/%0d exp=3/4", a_idx, a_out); end
    repeat (2) clk_step();
    n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy act=%0b exp=1", a_rdy); end
    #2 rst_n = 1'b0; model_reset();
    #1;
    n_tests++; if (a_out !== 3'd2) begin n_fail++; $display("FAIL mid_rst_out act=%0d exp=2", a_out); end
    n_tests++; if (a_idx !== 2'd1) begin n_fail++; $display("FAIL mid_rst_idx act=%0d exp=1", a_idx); end
    n_tests++; if (a_chg !== 1'b0) begin n_fail++; $display("FAIL mid_rst_chg act=%0b exp=0", a_chg); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; a_vld = 1'b0;
    n_tests++; if (a_idx !== 2'd1 || a_chg !== 1'b0) begin n_fail++; $display("FAIL mid_cmd_dropped act=%0d/%0b exp=1/0", a_idx, a_chg); end
  endtask

  task automatic test_wrap();
    do_reset();
    b_vld = 1'b1; b_cmd = 2'd1;
    clk_step();
    n_tests++; if (b_idx !== 2'd2 || b_out !== 4'd3 || b_chg !== 1'b1) begin n_fail++; $display("FAIL wrap_green act=%0d/%0d/%0b exp=2/3/1", b_idx, b_out, b_chg); end
    clk_step();
    n_tests++; if (b_idx !== 2'd0 || b_out !== 4'd1 || b_chg !== 1'b1) begin n_fail++; $display("FAIL wrap_fwd act=%0d/%0d/%0b exp=0/1/1", b_idx, b_out, b_chg); end
    b_cmd = 2'd2;
    clk_step();
    n_tests++; if (b_idx !== 2'd2 || b_out !== 4'd3) begin n_fail++; $display("FAIL wrap_rev act=%0d/%0d exp=2/3", b_idx, b_out); end
    b_vld = 1'b0;
    clk_step();
    n_tests++; if (b_chg !== 1'b0) begin n_fail++; $display("FAIL wrap_chg_clr act=%0b exp=0", b_chg); end
  endtask

  task automatic test_home_hold();
    do_reset();
    a_vld = 1'b1; a_cmd = 2'd3;
    repeat (3) clk_step();
    n_tests++; if (a_idx !== 2'd1 || a_chg !== 1'b0) begin n_fail++; $display("FAIL home_same act=%0d/%0b exp=1/0", a_idx, a_chg); end
    n_tests++; if (a_rdy !== 1'b1) begin n_fail++; $display("FAIL home_dwell_kept act=%0b exp=1", a_rdy); end
    a_vld = 1'b0;
    b_vld = 1'b1; b_cmd = 2'd2;
    clk_step();
    n_tests++; if (b_idx !== 2'd0) begin n_fail++; $display("FAIL hold_to_blue act=%0d exp=0", b_idx); end
    b_cmd = 2'd0;
    clk_step();
    n_tests++; if (b_out !== 4'd1 || b_idx !== 2'd0 || b_chg !== 1'b0) begin n_fail++; $display("FAIL hold_blue act=%0d/%0d/%0b exp=1/0/0", b_out, b_idx, b_chg); end
    b_vld = 1'b0;
  endtask

  task automatic test_auto();
`ifdef COLOR_SEQ_AUTO_EN
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      clk_step();
      n_tests++;
      if (a_idx !== 2'((1 + k / 4) % 4) || a_chg !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL auto_ring k=%0d act=%0d/%0b exp=%0d/%0b", k, a_idx, a_chg, (1 + k / 4) % 4, (k % 4) == 0);
      end
    end
    do_reset();
    repeat (3) clk_step();
    a_vld = 1'b1; a_cmd = 2'd2;
    clk_step();
    n_tests++; if (a_idx !== 2'd0 || a_out !== 3'd1 || a_chg !== 1'b1) begin n_fail++; $display("FAIL auto_rev_prio act=%0d/%0d/%0b exp=0/1/1", a_idx, a_out, a_chg); end
    do_reset();
    a_vld = 1'b1; a_cmd = 2'd0;
    repeat (4) clk_step();
    n_tests++; if (a_idx !== 2'd2 || a_chg !== 1'b1) begin n_fail++; $display("FAIL auto_hold act=%0d/%0b exp=2/1", a_idx, a_chg); end
    a_vld = 1'b0;
`else
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      clk_step();
      n_tests++;
      if (a_idx !== 2'd1 || a_chg !== 1'b0 || b_idx !== 2'd1) begin
        n_fail++; $display("FAIL no_auto k=%0d act=%0d/%0b/%0d exp=1/0/1", k, a_idx, a_chg, b_idx);
      end
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] o;
        logic [1:0] ix;
        logic       ch, rd;
        o  = (d == 0) ? {1'b0, a_out} : b_out;
        ix = (d == 0) ? a_idx : b_idx;
        ch = (d == 0) ? a_chg : b_chg;
        rd = (d == 0) ? a_rdy : b_rdy;
        n_tests++;
        if (o !== 4'(m_idx[d] + 1) || ix !== 2'(m_idx[d]) || ch !== m_chg[d] ||
            rd !== (m_dw[d] >= mind(d) - 1)) begin
          n_fail++;
          $display("FAIL rand_dut%0d cyc=%0d out=%0d/%0d idx=%0d/%0d chg=%0b/%0b rdy=%0b/%0b",
                   d, cyc, o, m_idx[d] + 1, ix, m_idx[d], ch, m_chg[d], rd, m_dw[d] >= mind(d) - 1);
        end
      end
      a_vld = ($urandom_range(0, 9) < 6); a_cmd = 2'($urandom_range(0, 3));
      b_vld = ($urandom_range(0, 9) < 4); b_cmd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0; model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        clk_step();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_vld = 1'b0; b_vld = 1'b0; a_cmd = 2'd0; b_cmd = 2'd0;
    model_reset();
    test_reset();
    test_dwell_gating();
    test_reset_mid();
    test_wrap();
    test_home_hold();
    test_auto();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_seq_fsm.md
COLOR_SEQ_FSM -- requirements
Module: color_seq_fsm

Interface
REQ-001 Parameter NUM_STATES, default 4, number of colour states in the ring, legal 2..4.
REQ-002 Parameter HOME, default 1 (Red), state index entered on reset and on HOME command, legal 0..NUM_STATES-1.
REQ-003 Parameter MIN_DWELL, default 2, minimum cycles spent in a state before a command is accepted, legal 1..255.
REQ-004 Parameter AUTO_DWELL, default 16, cycles after which auto-advance fires, legal MIN_DWELL..255.
REQ-005 Parameter OUT_WIDTH, default 3, width of out, legal >= 3.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 cmd  input  2  command: 0 HOLD, 1 ADVANCE, 2 REVERSE, 3 HOME.
REQ-009 cmd_valid  input  1  cmd is presented this cycle.
REQ-010 cmd_ready  output  1  block accepts cmd this cycle.
REQ-011 out  output  OUT_WIDTH  Moore colour code, zero-extended (state index + 1).
REQ-012 state_idx  output  2  current state index.
REQ-013 changed  output  1  one-cycle pulse in first cycle of a newly entered state.

Function
REQ-014 States SHALL be Blue=0, Red=1, Green=2, Yellow=3; only indices below NUM_STATES are reachable.
REQ-015 dwell_cnt SHALL clear to 0 on state entry, then increment each cycle, saturating at 255.
REQ-016 cmd_ready SHALL be high iff dwell_cnt >= MIN_DWELL-1, and SHALL depend only on registered state, never on cmd_valid or cmd.
REQ-017 A command is accepted when cmd_valid and cmd_ready are both high on a rising edge; the new state is visible on out the cycle after acceptance.
REQ-018 ADVANCE: idx+1, wrapping NUM_STATES-1 -> 0.
REQ-019 REVERSE: idx-1, wrapping 0 -> NUM_STATES-1.
REQ-020 HOME: go to HOME; if already in HOME, no transition, dwell_cnt SHALL NOT clear, changed stays low.
REQ-021 HOLD: accepted, no transition, dwell_cnt keeps counting.
REQ-022 cmd_valid while cmd_ready is low SHALL be ignored (not queued); the source must hold it.
REQ-023 changed SHALL be registered, high for exactly one cycle per real transition, never for HOLD or same-state HOME.
REQ-024 out SHALL be decoded only from the current state (Moore); there is no combinational path from cmd to out.

Reset
REQ-025 On rst_n low: state=HOME, dwell_cnt=0, changed=0, cmd_ready=0 (if MIN_DWELL>1), out=HOME+1, immediately and asynchronously.
REQ-026 Reset asserted mid-dwell or in the same cycle as an accepted command SHALL win; the command is dropped.
REQ-027 After rst_n deasserts, the first rising edge SHALL start dwell counting from 0.

Configuration
REQ-028 Macro COLOR_SEQ_AUTO_EN: when defined, if dwell_cnt == AUTO_DWELL-1 and no ADVANCE/REVERSE/HOME command is accepted that edge, the state SHALL auto-advance as for ADVANCE, with changed pulsing.
REQ-029 Accepted ADVANCE/REVERSE/HOME SHALL take priority over auto-advance in the same cycle; an accepted HOLD SHALL NOT suppress auto-advance.
REQ-030 Without COLOR_SEQ_AUTO_EN, no auto-advance logic is present, AUTO_DWELL is ignored, and a state holds indefinitely with no command.

Structure
REQ-031 A shared package color_seq_pkg SHALL hold the Color_state enum (2-bit), the cmd encoding enum, and the function next_idx(idx, dir, num_states).
REQ-032 One sub-module, color_seq_dwell, SHALL implement the saturating dwell counter plus ready and auto-fire compare; the top holds the state register and output decode.

Verification
REQ-033 Reset: drive rst_n=0 mid-run with state=Yellow -> out=2, state_idx=1 in the same cycle, no changed pulse.
REQ-034 Dwell gating: MIN_DWELL=3, cmd_valid=1, cmd=ADVANCE from reset -> cmd_ready rises at dwell_cnt=2; out goes 2->3 one cycle later; changed pulses once.
REQ-035 Wrap: NUM_STATES=3, ADVANCE from Green -> Blue (out=1); REVERSE from Blue -> Green (out=3).
REQ-036 HOME/HOLD: HOME while in Red -> no changed pulse, dwell_cnt continues; HOLD in Blue -> state unchanged, out=1.
REQ-037 Auto (COLOR_SEQ_AUTO_EN, AUTO_DWELL=4, no commands) -> Red->Green->Yellow->Blue every 4 cycles; REVERSE accepted on the auto-fire cycle -> Blue, not Green.
